// File: rtl/key_store.sv
// key_store: read-only key slots streamed one 16-bit word at a time over a
// valid/ready handshake. Each slot can be locked until the next reset.
module key_store #(
  parameter int NUM_SLOTS = 4,
  parameter int KEY_WORDS = 8,
  parameter int SLOT_MSB  = 1,
  parameter int WORD_MSB  = 2
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              exec_en,
  input  logic              rd_req,
  input  logic [SLOT_MSB:0] rd_slot,
  input  logic              lock_req,
  input  logic [SLOT_MSB:0] lock_slot,
  input  logic              key_ready,
  output logic              rd_ack,
  output logic [15:0]       key_dout,
  output logic              key_valid,
  output logic              key_last,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  localparam logic [WORD_MSB:0] ONE_W = 1;

  state_t               state_q, state_d;
  logic [SLOT_MSB:0]    slot_p0, slot_d;
  logic [WORD_MSB:0]    cnt_p0, cnt_d;
  logic [15:0]          dout_p1, dout_d;
  logic                 vld_p1, vld_d;
  logic                 last_p1, last_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [NUM_SLOTS-1:0] lock_q;
  logic                 slot_ok, rd_locked, same_lock, cur_lock_hit;

  // Key ROM contents: upper nibble A, then slot number, then word index.
  function automatic logic [15:0] rom_word(input logic [SLOT_MSB:0] s,
                                           input logic [WORD_MSB:0] w);
    logic [3:0] s4;
    logic [7:0] w8;
    s4 = 4'(s);
    w8 = 8'(w);
    return {4'hA, s4, w8};
  endfunction

  // Request qualification: slot range, existing lock, and a lock arriving
  // in the same cycle as the request for that slot.
  always_comb begin
    slot_ok   = (int'(rd_slot) < NUM_SLOTS);
    rd_locked = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (int'(rd_slot) == i) rd_locked = lock_q[i];
    end
    same_lock    = lock_req && (lock_slot == rd_slot);
    cur_lock_hit = lock_req && (lock_slot == slot_p0);
  end

  // Next-state and next-output logic; aborts take priority over transfers.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_p0;
    cnt_d   = cnt_p0;
    dout_d  = dout_p1;
    vld_d   = vld_p1;
    last_d  = last_p1;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (exec_en && slot_ok && !rd_locked && !same_lock) begin
            state_d = LOAD;
            slot_d  = rd_slot;
            cnt_d   = '0;
            ack_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD, STREAM: begin
        if (!exec_en || cur_lock_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
          dout_d  = 16'h0000;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          err_d   = 1'b1;
        end else if (state_q == LOAD) begin
          state_d = STREAM;
          dout_d  = rom_word(slot_p0, '0);
          vld_d   = 1'b1;
          last_d  = (KEY_WORDS == 1);
        end else if (key_ready) begin
          if (last_p1) begin
            state_d = IDLE;
            cnt_d   = '0;
            dout_d  = 16'h0000;
            vld_d   = 1'b0;
            last_d  = 1'b0;
          end else begin
            cnt_d  = cnt_p0 + ONE_W;
            dout_d = rom_word(slot_p0, cnt_p0 + ONE_W);
            last_d = (int'(cnt_p0) + 1 == KEY_WORDS - 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: control state, captured slot and word counter.
  // Stage p1: registered key word with its valid/last flags.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      slot_p0 <= '0;
      cnt_p0  <= '0;
      dout_p1 <= 16'h0000;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_p0 <= slot_d;
      cnt_p0  <= cnt_d;
      dout_p1 <= dout_d;
      vld_p1  <= vld_d;
      last_p1 <= last_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Lock bits only ever get set; out-of-range lock slots match no bit.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (lock_req && int'(lock_slot) == i) lock_q[i] <= 1'b1;
      end
    end
  end

  assign rd_ack    = ack_q;
  assign err       = err_q;
  assign key_dout  = dout_p1;
  assign key_valid = vld_p1;
  assign key_last  = last_p1;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/key_store.md
KEY_STORE -- requirements
Module: key_store

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, meaning number of independent key slots.
REQ-002 SHALL have parameter KEY_WORDS, default 8, meaning 16-bit words per key.
REQ-003 SHALL have parameter SLOT_MSB, default 1, meaning MSB of the slot index bus.
REQ-004 SHALL have parameter WORD_MSB, default 2, meaning MSB of the internal word counter.
REQ-005 SHALL have port mclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port exec_en, input, 1 bit: access permitted (trusted code executing).
REQ-008 SHALL have port rd_req, input, 1 bit: request a key stream.
REQ-009 SHALL have port rd_slot, input, [SLOT_MSB:0]: slot to stream, sampled with rd_req.
REQ-010 SHALL have port lock_req, input, 1 bit: permanently disable slot lock_slot until reset.
REQ-011 SHALL have port lock_slot, input, [SLOT_MSB:0]: slot to lock.
REQ-012 SHALL have port key_ready, input, 1 bit: consumer accepts key_dout.
REQ-013 SHALL have port rd_ack, output, 1 bit: one-cycle pulse, request accepted.
REQ-014 SHALL have port key_dout, output, 16 bits: current key word.
REQ-015 SHALL have port key_valid, output, 1 bit: key_dout valid.
REQ-016 SHALL have port key_last, output, 1 bit: current word is the final word of the key.
REQ-017 SHALL have port busy, output, 1 bit: FSM not in IDLE.
REQ-018 SHALL have port err, output, 1 bit: one-cycle pulse on rejected request or abort.

Function
REQ-019 SHALL hold NUM_SLOTS*KEY_WORDS 16-bit words, read-only; default content of slot s, word w = {4'hA, s[3:0], w[7:0]}.
REQ-020 SHALL implement FSM states IDLE, LOAD, STREAM.
REQ-021 SHALL accept a request in IDLE when rd_req=1, exec_en=1, rd_slot<NUM_SLOTS, slot not locked, lock_req not naming rd_slot in the same cycle; next state LOAD, rd_ack=1 for that next cycle.
REQ-022 SHALL reject any other rd_req in IDLE: state stays IDLE, err=1 next cycle, no rd_ack.
REQ-023 SHALL ignore rd_req while busy (no ack, no err).
REQ-024 SHALL move LOAD -> STREAM after one cycle (synchronous array read); first key_valid=1 two cycles after the accepting edge.
REQ-025 SHALL in STREAM present word w with key_valid=1; advance w only on key_valid&key_ready; hold key_dout stable while key_ready=0.
REQ-026 SHALL assert key_last with word KEY_WORDS-1; transfer of that word returns FSM to IDLE and drops key_valid next cycle.
REQ-027 SHALL drive key_dout=16'h0000 whenever key_valid=0.
REQ-028 SHALL abort when exec_en=0 in LOAD or STREAM: next cycle state IDLE, key_valid=0, key_dout=0, err=1 for one cycle.
REQ-029 SHALL set lock bit for lock_slot on lock_req (lock_slot>=NUM_SLOTS ignored); lock bits are set-only.
REQ-030 SHALL abort per REQ-028 (err pulse) when lock_req names the slot being streamed.
REQ-031 SHALL support back-to-back streams: new request accepted in the cycle after returning to IDLE.

Reset
REQ-032 SHALL, on reset_n=0, immediately force state IDLE, word counter 0, all lock bits clear, rd_ack=0, key_valid=0, key_last=0, key_dout=0, busy=0, err=0.
REQ-033 SHALL abandon any stream in progress on reset without emitting further words.

Verification
REQ-034 Bench SHALL cover: exec_en=1, rd_req slot 2, key_ready=1 -> rd_ack cycle+1, words 16'hA200..16'hA207 on cycles +2..+9, key_last with 16'hA207, busy low cycle +10.
REQ-035 Bench SHALL cover: stream slot 1, key_ready=0 for 3 cycles at word 3 -> key_dout holds 16'hA103, no word skipped or repeated.
REQ-036 Bench SHALL cover: lock_req slot 0, then rd_req slot 0 -> err pulse, no rd_ack, key_valid stays 0; slot 1 still streams.
REQ-037 Bench SHALL cover: exec_en dropped during word 4 of slot 3 -> key_valid=0, key_dout=0, err pulse next cycle, state IDLE.
REQ-038 Bench SHALL cover: rd_req with exec_en=0 or rd_slot>=NUM_SLOTS (NUM_SLOTS=3 build) -> err pulse only.
REQ-039 Bench SHALL cover: reset_n low mid-stream -> all outputs zero asynchronously, locks cleared, previously locked slot streams after reset.
